wkup_detect: RTL and testbench
==============================

# wkup_detect

Multi-channel wakeup detector that sits directly upstream of the power manager and drives its `wakeups_i` vector. Each channel synchronizes an asynchronous pad or peripheral signal, qualifies it with a programmable edge/level mode and debounce threshold, and raises a sticky wake request. The request stays asserted until software clears it, so it satisfies the power manager's minimum pulse requirement of one `clk_slow_i` period.

## Interface
- NumChan, 4, number of independent wakeup channels
- CntW, 16, debounce counter / threshold width
- clk_i  in  1  detector clock
- rst_ni  in  1  reset; rst_ni, asynchronous, active-low; clock clk_i
- wkup_src_i  in  NumChan  raw asynchronous wakeup sources
- en_i  in  NumChan  per-channel enable (quasi-static CSR)
- mode_i  in  NumChan×3  per-channel mode: 0 rising, 1 falling, 2 either edge, 3 level high, 4 level low, 5–7 disabled
- thresh_i  in  NumChan×CntW  debounce threshold in clk_i cycles
- clr_i  in  NumChan  single-cycle clear pulse per channel (CSR write-1-to-clear)
- wkup_o  out  NumChan  sticky wake requests to the power manager
- wkup_any_o  out  1  OR of wkup_o
- debouncing_o  out  NumChan  channel is in DEBOUNCE state (status CSR)

## Operation
- Each source passes through a 2-flop synchronizer, giving `s`. The previous value is kept in `s_prev`, which resets to 0.
- Trigger condition by mode:
  - rising: s & ~s_prev
  - falling: ~s & s_prev
  - either edge: s ^ s_prev
  - level high: s
  - level low: ~s
- On a trigger, the channel captures `lvl` = s.
- Hold condition:
  - edge modes: s == lvl
  - level modes: the level still matches
- Per-channel FSM states: IDLE, DEBOUNCE, ASSERTED. Reset state is IDLE.
  - IDLE → DEBOUNCE when en_i and a trigger occur. cnt is set to 0.
  - DEBOUNCE:
    - hold false → IDLE
    - hold true and cnt >= thresh_i → ASSERTED
    - otherwise cnt <= cnt + 1
  - ASSERTED: wkup_o = 1. clr_i → IDLE.
  - From any state, en_i low or a disabled mode → IDLE next cycle. cnt is cleared.
- Counter arithmetic:
  - The `>=` compare keeps cnt bounded by thresh_i and never wraps.
  - If thresh_i is lowered mid-debounce below cnt, the channel asserts on the next cycle.
- thresh_i = 0: the channel asserts on the first DEBOUNCE cycle.
- clr_i while in IDLE or DEBOUNCE has no effect.
- clr_i in the same cycle as a new trigger in ASSERTED: the clear wins and the channel goes to IDLE.
  - Level modes re-trigger on the next cycle if the level persists.
  - Edge modes require a fresh edge.
- Channels are fully independent. wkup_any_o is combinational from the registered wkup_o.

## Timing
- Every output resets to 0: wkup_o, wkup_any_o, debouncing_o. Synchronizer flops, s_prev, lvl and cnt also reset to 0.
- Latency: a source change sampled at edge k produces `s` after edge k+1. The channel enters DEBOUNCE at edge k+2. wkup_o rises at edge k+3+thresh_i, provided the hold condition is held throughout.
- Release: clr_i sampled at edge j → wkup_o low after edge j; debouncing_o low after edge j.
- en_i deassert sampled at edge j → all of that channel's outputs low after edge j.
- A glitch shorter than thresh_i+1 synchronized cycles never asserts wkup_o.
- Reset mid-debounce or mid-assert: the channel returns to IDLE with its outputs immediately low (asynchronous).
- wkup_o is glitch-free because it is driven from a flop (FSM state decode registered), as required for CDC into the slow domain.

## Structure
- Package `wkup_detect_pkg` holds:
  - `wkup_mode_e` (3-bit enum, values above)
  - `wkup_chan_state_e` (IDLE, DEBOUNCE, ASSERTED)
  - `WkupModeW = 3`
- Sub-module `wkup_detect_chan`, one channel, instantiated NumChan times in a generate loop. It contains:
  - the synchronizer, using `prim_flop_2sync`
  - the edge logic
  - the FSM
  - the counter
- The top-level module contains only the generate loop and the wkup_any_o reduction.

## Test plan
- Rising, ch0, thresh=3: drive src 0→1 at edge 10 and hold → debouncing_o[0] high from edge 12; wkup_o[0] rises at edge 16; clr_i pulse at edge 20 → wkup_o[0]=0 after edge 20.
- Glitch, level-high, thresh=5: pulse src high for 4 cycles → debouncing_o goes high, then the channel returns to IDLE; wkup_o stays 0.
- Either-edge, thresh=0: src 1→0 → wkup_o rises 3 cycles after the sample edge.
- Clear vs retrigger, level-low with src held low: clr_i while in ASSERTED → wkup_o drops for exactly 1 cycle then re-asserts after thresh+1 cycles.
- Mid-debounce cases, ch2, thresh=100:
  - deassert en_i at cnt=50 → IDLE, outputs 0.
  - separately, lower thresh to 10 at cnt=50 → assert next cycle.
  - apply rst_ni low → all outputs 0 asynchronously.
- Independence and disabled modes: channels 0–3 with staggered triggers produce correct individual wkup_o and wkup_any_o; mode=6 never asserts.

Source files
------------

// File: rtl/wkup_detect_pkg.sv
// Shared types and helpers for the wakeup detector: channel modes, channel
// FSM states and the per-mode trigger / hold qualification.
package wkup_detect_pkg;

    localparam int unsigned WkupModeW = 3;

    typedef enum logic [WkupModeW-1:0] {
        ModeRise    = 3'd0,
        ModeFall    = 3'd1,
        ModeEither  = 3'd2,
        ModeLvlHigh = 3'd3,
        ModeLvlLow  = 3'd4,
        ModeOff5    = 3'd5,
        ModeOff6    = 3'd6,
        ModeOff7    = 3'd7
    } wkup_mode_e;

    typedef enum logic [1:0] {
        ChanIdle     = 2'd0,
        ChanDebounce = 2'd1,
        ChanAsserted = 2'd2
    } wkup_chan_state_e;

    // Encodings 5..7 are reserved and treated as "channel off".
    function automatic logic mode_is_off(input wkup_mode_e mode);
        logic off;
        case (mode)
            ModeRise, ModeFall, ModeEither, ModeLvlHigh, ModeLvlLow: off = 1'b0;
            default:                                                 off = 1'b1;
        endcase
        return off;
    endfunction

    // Does the current synchronized sample start a debounce window?
    function automatic logic mode_trigger(input wkup_mode_e mode,
                                          input logic       s,
                                          input logic       s_prev);
        logic trig;
        case (mode)
            ModeRise:    trig = s & ~s_prev;
            ModeFall:    trig = ~s & s_prev;
            ModeEither:  trig = s ^ s_prev;
            ModeLvlHigh: trig = s;
            ModeLvlLow:  trig = ~s;
            default:     trig = 1'b0;
        endcase
        return trig;
    endfunction

    // Is the debounce window still being held? Edge modes hold while the
    // input stays at the level captured on the trigger; level modes hold
    // while the configured level is still present.
    function automatic logic mode_hold(input wkup_mode_e mode,
                                       input logic       s,
                                       input logic       lvl);
        logic hold;
        case (mode)
            ModeLvlHigh: hold = s;
            ModeLvlLow:  hold = ~s;
            default:     hold = (s == lvl);
        endcase
        return hold;
    endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for bringing asynchronous signals into clk_i.
module prim_flop_2sync #(
    parameter int unsigned          Width      = 1,
    parameter logic [Width-1:0]     ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;

    // Two back-to-back capture stages to resolve metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= ResetValue;
            sync2_q <= ResetValue;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/wkup_detect_chan.sv
// One wakeup channel: synchronizer, edge/level qualification, debounce
// counter and the IDLE/DEBOUNCE/ASSERTED request FSM.
module wkup_detect_chan
    import wkup_detect_pkg::*;
#(
    parameter int unsigned CntW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wkup_src_i,
    input  logic                 en_i,
    input  logic [WkupModeW-1:0] mode_i,
    input  logic [CntW-1:0]      thresh_i,
    input  logic                 clr_i,
    output logic                 wkup_o,
    output logic                 debouncing_o
);

    wkup_mode_e       mode;
    logic             s;
    logic             s_prev_q;
    logic             lvl_q, lvl_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    wkup_chan_state_e state_q, state_d;
    logic             wkup_q, deb_q;
    logic             chan_off, trig, hold;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (wkup_src_i),
        .q_o    (s)
    );

    assign mode     = wkup_mode_e'(mode_i);
    assign chan_off = !en_i || mode_is_off(mode);
    assign trig     = mode_trigger(mode, s, s_prev_q);
    assign hold     = mode_hold(mode, s, lvl_q);

    // Next-state logic; disable takes priority over every state, and the
    // >= compare bounds cnt by thresh_i so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        if (chan_off) begin
            state_d = ChanIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ChanIdle: begin
                    if (trig) begin
                        state_d = ChanDebounce;
                        cnt_d   = '0;
                        lvl_d   = s;
                    end
                end
                ChanDebounce: begin
                    if (!hold) begin
                        state_d = ChanIdle;
                        cnt_d   = '0;
                    end else if (cnt_q >= thresh_i) begin
                        state_d = ChanAsserted;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ChanAsserted: begin
                    // A clear beats any trigger seen in the same cycle.
                    if (clr_i) begin
                        state_d = ChanIdle;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ChanIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, captured level and edge history registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ChanIdle;
            cnt_q    <= '0;
            lvl_q    <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lvl_q    <= lvl_d;
            s_prev_q <= s;
        end
    end

    // Outputs are decoded from the next state and registered, so wkup_o is a
    // clean flop output safe to cross into the slow power-manager domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wkup_q <= 1'b0;
            deb_q  <= 1'b0;
        end else begin
            wkup_q <= (state_d == ChanAsserted);
            deb_q  <= (state_d == ChanDebounce);
        end
    end

    assign wkup_o       = wkup_q;
    assign debouncing_o = deb_q;

endmodule

// File: rtl/wkup_detect.sv
// Multi-channel wakeup detector feeding the power manager wakeup vector.
// Channels are fully independent; wkup_any_o is the OR of the registered
// per-channel requests.
module wkup_detect
    import wkup_detect_pkg::*;
#(
    parameter int unsigned NumChan = 4,
    parameter int unsigned CntW    = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumChan-1:0]             wkup_src_i,
    input  logic [NumChan-1:0]             en_i,
    input  logic [NumChan*WkupModeW-1:0]   mode_i,
    input  logic [NumChan*CntW-1:0]        thresh_i,
    input  logic [NumChan-1:0]             clr_i,
    output logic [NumChan-1:0]             wkup_o,
    output logic                           wkup_any_o,
    output logic [NumChan-1:0]             debouncing_o
);

    for (genvar i = 0; i < NumChan; i++) begin : g_chan
        wkup_detect_chan #(
            .CntW (CntW)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .wkup_src_i   (wkup_src_i[i]),
            .en_i         (en_i[i]),
            .mode_i       (mode_i[i*WkupModeW +: WkupModeW]),
            .thresh_i     (thresh_i[i*CntW +: CntW]),
            .clr_i        (clr_i[i]),
            .wkup_o       (wkup_o[i]),
            .debouncing_o (debouncing_o[i])
        );
    end

    assign wkup_any_o = |wkup_o;

endmodule

// File: tb/tb_wkup_detect.sv
// Scoreboard bench for wkup_detect: stimulus pushes expected output-change
// events (cycle, wkup vector, debouncing vector); a monitor pops one event
// each time the DUT outputs change and compares.
module tb_wkup_detect;
    import wkup_detect_pkg::*;

    localparam int NumChan = 4;
    localparam int CntW    = 16;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic [NumChan-1:0]           wkup_src_i = '0;
    logic [NumChan-1:0]           en_i = '0;
    logic [NumChan*WkupModeW-1:0] mode_i = '0;
    logic [NumChan*CntW-1:0]      thresh_i = '0;
    logic [NumChan-1:0]           clr_i = '0;
    logic [NumChan-1:0]           wkup_o;
    logic                         wkup_any_o;
    logic [NumChan-1:0]           debouncing_o;

    wkup_detect #(.NumChan(NumChan), .CntW(CntW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wkup_src_i   (wkup_src_i),
        .en_i         (en_i),
        .mode_i       (mode_i),
        .thresh_i     (thresh_i),
        .clr_i        (clr_i),
        .wkup_o       (wkup_o),
        .wkup_any_o   (wkup_any_o),
        .debouncing_o (debouncing_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge number: value equals n after the n-th rising edge.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int                 c;
        logic [NumChan-1:0] w;
        logic [NumChan-1:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Return just after edge e-1 so anything driven now is sampled at edge e.
    task automatic go(input int e);
        while (cyc < e - 1) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input logic [3:0] w, input logic [3:0] d);
        ev_t ev;
        ev.c = c;
        ev.w = w;
        ev.d = d;
        exp_q.push_back(ev);
    endtask

    task automatic set_ch(input int ch, input logic en, input logic [2:0] m,
                          input logic [15:0] t);
        en_i[ch]                     = en;
        mode_i[ch*WkupModeW +: WkupModeW] = m;
        thresh_i[ch*CntW +: CntW]    = t;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [NumChan-1:0] prev_w = '0;
        logic [NumChan-1:0] prev_d = '0;
        ev_t ev;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_w = wkup_o;
                prev_d = debouncing_o;
            end else if (wkup_o !== prev_w || debouncing_o !== prev_d) begin
                prev_w = wkup_o;
                prev_d = debouncing_o;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d wkup=%b deb=%b", cyc, wkup_o, debouncing_o);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc != ev.c || wkup_o !== ev.w || debouncing_o !== ev.d ||
                        wkup_any_o !== (ev.w != '0)) begin
                        errors++;
                        $display("FAIL event actual cyc=%0d wkup=%b any=%b deb=%b required cyc=%0d wkup=%b any=%b deb=%b",
                                 cyc, wkup_o, wkup_any_o, debouncing_o, ev.c, ev.w, (ev.w != '0), ev.d);
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset state.
        go(2);
        chk("reset_wkup", 32'(wkup_o), 32'h0);
        chk("reset_any", 32'(wkup_any_o), 32'h0);
        chk("reset_deb", 32'(debouncing_o), 32'h0);
        go(3);
        rst_ni = 1'b1;

        // Rising edge, ch0, thresh 3; clear releases; no retrigger without an edge.
        go(5);  set_ch(0, 1'b1, 3'd0, 16'd3);
        go(10); wkup_src_i[0] = 1'b1;
        expect_ev(12, 4'b0000, 4'b0001);
        expect_ev(16, 4'b0001, 4'b0000);
        go(20); clr_i = 4'b0001;
        expect_ev(20, 4'b0000, 4'b0000);
        go(21); clr_i = '0;
        go(22); wkup_src_i[0] = 1'b0;
        go(24); en_i[0] = 1'b0;

        // Level-high glitch on ch1, 4 cycles against thresh 5: never asserts.
        go(30); set_ch(1, 1'b1, 3'd3, 16'd5);
        go(32); wkup_src_i[1] = 1'b1;
        expect_ev(34, 4'b0000, 4'b0010);
        go(36); wkup_src_i[1] = 1'b0;
        expect_ev(38, 4'b0000, 4'b0000);
        go(40); en_i[1] = 1'b0;

        // Either-edge ch3, thresh 0, falling input: asserts 3 cycles after sampling.
        go(44); wkup_src_i[3] = 1'b1;
        go(48); set_ch(3, 1'b1, 3'd2, 16'd0);
        go(52); wkup_src_i[3] = 1'b0;
        expect_ev(54, 4'b0000, 4'b1000);
        expect_ev(55, 4'b1000, 4'b0000);
        go(58); clr_i = 4'b1000;
        expect_ev(58, 4'b0000, 4'b0000);
        go(59); clr_i = '0;
        go(60); en_i[3] = 1'b0;

        // Level-low ch1 with src held low, thresh 2: clear then re-trigger;
        // a clear during DEBOUNCE is ignored.
        go(64); set_ch(1, 1'b1, 3'd4, 16'd2);
        expect_ev(64, 4'b0000, 4'b0010);
        expect_ev(67, 4'b0010, 4'b0000);
        go(72); clr_i = 4'b0010;
        expect_ev(72, 4'b0000, 4'b0000);
        expect_ev(73, 4'b0000, 4'b0010);
        expect_ev(76, 4'b0010, 4'b0000);
        go(73); clr_i = '0;
        go(74); clr_i = 4'b0010;
        go(75); clr_i = '0;
        go(80); en_i[1] = 1'b0;
        expect_ev(80, 4'b0000, 4'b0000);

        // ch2 thresh 100: disable at cnt=50.
        go(84); set_ch(2, 1'b1, 3'd0, 16'd100);
        go(90); wkup_src_i[2] = 1'b1;
        expect_ev(92, 4'b0000, 4'b0100);
        go(143); en_i[2] = 1'b0;
        expect_ev(143, 4'b0000, 4'b0000);

        // ch2: lower thresh to 10 at cnt=50 -> asserts on that edge.
        go(150); wkup_src_i[2] = 1'b0;
        go(152); en_i[2] = 1'b1;
        go(160); wkup_src_i[2] = 1'b1;
        expect_ev(162, 4'b0000, 4'b0100);
        go(213); thresh_i[2*CntW +: CntW] = 16'd10;
        expect_ev(213, 4'b0100, 4'b0000);
        go(216); clr_i = 4'b0100;
        expect_ev(216, 4'b0000, 4'b0000);
        go(217); clr_i = '0;

        // ch2: asynchronous reset in the middle of a debounce.
        go(220); thresh_i[2*CntW +: CntW] = 16'd100; wkup_src_i[2] = 1'b0;
        go(224); wkup_src_i[2] = 1'b1;
        expect_ev(226, 4'b0000, 4'b0100);
        go(240);
        #2;
        rst_ni = 1'b0;
        en_i = '0;
        wkup_src_i = '0;
        #1;
        chk("async_rst_wkup", 32'(wkup_o), 32'h0);
        chk("async_rst_any", 32'(wkup_any_o), 32'h0);
        chk("async_rst_deb", 32'(debouncing_o), 32'h0);
        @(posedge clk_i);
        #4;
        rst_ni = 1'b1;

        // Independence: staggered triggers on ch0/1/2, ch3 in disabled mode 6.
        go(250);
        set_ch(0, 1'b1, 3'd0, 16'd1);
        set_ch(1, 1'b1, 3'd1, 16'd2);
        set_ch(2, 1'b1, 3'd3, 16'd0);
        set_ch(3, 1'b1, 3'd6, 16'd0);
        wkup_src_i[1] = 1'b1;
        go(260); wkup_src_i[0] = 1'b1;
        expect_ev(262, 4'b0000, 4'b0001);
        go(262); wkup_src_i[2] = 1'b1;
        expect_ev(264, 4'b0001, 4'b0100);
        expect_ev(265, 4'b0101, 4'b0000);
        go(264); wkup_src_i[1] = 1'b0;
        expect_ev(266, 4'b0101, 4'b0010);
        expect_ev(269, 4'b0111, 4'b0000);
        go(266); wkup_src_i[3] = 1'b1;
        go(275); wkup_src_i[3] = 1'b0;
        go(280); clr_i = 4'b1111;
        expect_ev(280, 4'b0000, 4'b0000);
        expect_ev(281, 4'b0000, 4'b0100);
        expect_ev(282, 4'b0100, 4'b0000);
        go(281); clr_i = '0;
        go(286); en_i = '0;
        expect_ev(286, 4'b0000, 4'b0000);

        go(300);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events actual=%0d required=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].c);
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                repeat (5000) @(posedge clk_i);
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
            begin
                stimulus();
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
